cla_pipe_adder: RTL
===================

// Module: cla_pipe_adder
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 64-bit combinational CLA.
//  Splits a WIDTH-bit add into STAGES registered segments, carry forwarded through pipeline registers.
//  Valid/ready handshake both sides with an opaque tag; sits between operand source and result consumer in datapath labs.
// PARAMETERS
//  WIDTH   64  operand/sum width; WIDTH % (STAGES*4) == 0 (elaboration error otherwise)
//  STAGES  2   pipeline segments = latency in cycles; 1..WIDTH/4
//  TAG_W   4   width of pass-through tag
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        block can accept beat this cycle
//  in_a       in   WIDTH    operand A
//  in_b       in   WIDTH    operand B
//  cin        in   1        carry-in (add mode only)
//  sub        in   1        1: A - B (A + ~B + 1, cin ignored); 0: A + B + cin
//  in_tag     in   TAG_W    returned unchanged with result
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  sum        out  WIDTH    result
//  cout       out  1        carry-out (sub mode: 1 = no borrow)
//  gp         out  1        group propagate of whole word (AND of all p_i, p_i = a_i ^ b_i', b' = inverted B in sub)
//  gg         out  1        group generate of whole word (independent of cin)
//  out_tag    out  TAG_W    tag of this result
// BEHAVIOUR
//  - Reset (rst_n low, async): all stage valid bits 0, out_valid=0, sum=0, cout=0, gp=0, gg=0, out_tag=0.
//  - Reset mid-operation: all in-flight beats discarded immediately; nothing emitted after release until new accepts.
//  - Global advance: adv = !out_valid || out_ready; in_ready = adv. Accept when in_valid && in_ready.
//  - Stage k (0..STAGES-1) adds slice [(k+1)*S-1 : k*S], S = WIDTH/STAGES, using 4-bit CLA blocks + slice-level lookahead;
//    carry-in of stage k = registered carry-out of stage k-1 (stage 0: sub ? 1 : cin).
//  - Operand slices for later stages are skew-delayed; completed low sum slices delay-aligned to exit together.
//  - Latency: beat accepted at cycle t appears on out_* at t+STAGES when never stalled; one result/cycle throughput.
//  - Stall (out_valid && !out_ready): every stage register, incl. outputs, holds; in_ready=0; no beat lost or duplicated.
//  - Bubbles not collapsed: invalid stages advance with the pipe; stage valid bit qualifies its data.
//  - gp/gg: combined per stage from block gp/gg, folded through pipeline, registered with sum.
//  - Arithmetic is modulo 2^WIDTH; cout is bit WIDTH of the full-width result.
//  - Outputs hold last value while out_valid=0 after a transfer (not cleared).
// CONFIGURATION
//  CLA_PIPE_OVF_EN defined: extra output port ovf (out, 1) = signed two's-complement overflow,
//    ovf = carry into MSB ^ cout; registered/stalled like sum; reset 0.
//  Not defined: port absent, no MSB-carry tracking logic.
// STRUCTURE
//  cla_pkg: localparam CLA_BLK_W=4; function for slice width/stage count checks; typedef of stage record
//    {valid, tag, sub, carry, gp, gg, partial sum, pending A/B slices}.
//  Sub-module cla_block4: combinational 4-bit CLA (a, b, cin -> sum, gp, gg), instantiated WIDTH/4 times.
//  Top holds stage registers, skew/align shift logic, handshake.
// TESTING (WIDTH=64, STAGES=2 unless stated)
//  1 Reset: rst_n=0 mid-stream with 2 beats in flight -> out_valid=0 at once, no output after release until new beat.
//  2 Add: A=64'hFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> sum=0, cout=1, gp=1, gg=0, exactly 2 cycles after accept.
//  3 Sub: A=5, B=7, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0; A=7, B=5 -> sum=2, cout=1.
//  4 Backpressure: stream tags 0..7 back-to-back, out_ready toggles 1,0,0,1,... -> results in tag order, none lost/duplicated, in_ready tracks adv.
//  5 Params: WIDTH=32,STAGES=4 and WIDTH=16,STAGES=1 vs 1000 random beats -> {cout,sum} == a+b+cin (ref model), latency = STAGES.
//  6 CLA_PIPE_OVF_EN: A=64'h7FFF_FFFF_FFFF_FFFF, B=1 -> ovf=1, cout=0; A=-1, B=1 -> ovf=0, cout=1.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants, configuration check and per-stage control record for cla_pipe_adder.
package cla_pkg;

    localparam int unsigned CLA_BLK_W = 4;

    // Fixed-width part of a pipeline stage record; tag, partial sum and pending
    // operand slices depend on the adder parameters and live beside it in the top.
    typedef struct packed {
        logic valid;
        logic carry;
        logic gp;
        logic gg;
    } cla_stage_t;

    function automatic bit cla_cfg_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width / CLA_BLK_W) &&
               (width % (stages * CLA_BLK_W) == 0);
    endfunction

endpackage

// File: rtl/cla_block4.sv
// Combinational 4-bit carry-lookahead block: sum plus block propagate/generate.
module cla_block4
    import cla_pkg::*;
(
    input  logic [CLA_BLK_W-1:0] a,
    input  logic [CLA_BLK_W-1:0] b,
    input  logic                 cin,
    output logic [CLA_BLK_W-1:0] sum,
    output logic                 gp,
    output logic                 gg
);

    logic [CLA_BLK_W-1:0] p;
    logic [CLA_BLK_W-1:0] g;
    logic [CLA_BLK_W-1:0] c;

    assign p  = a ^ b;
    assign g  = a & b;
    // gp/gg kept apart from the carry chain so they never depend on cin
    assign gp = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    always_comb begin
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        sum  = p ^ c;
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, STAGES registered slices with valid/ready handshake.
// Optional signed-overflow output enabled by defining CLA_PIPE_OVF_EN.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             gp,
    output logic             gg,
    output logic [TAG_W-1:0] out_tag
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned S  = WIDTH / STAGES;
    localparam int unsigned NB = S / CLA_BLK_W;

    if (!cla_cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("cla_pipe_adder: WIDTH must be a multiple of 4*STAGES with 1 <= STAGES <= WIDTH/4");
    end

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned REM = WIDTH - k * S;

        logic [REM-1:0]       a_src;
        logic [REM-1:0]       b_src;
        cla_stage_t           ctl_src;
        logic [TAG_W-1:0]     tag_src;
        logic [S-1:0]         s_sum;
        logic [NB-1:0]        bgp;
        logic [NB-1:0]        bgg;
        logic [NB:0]          c;
        logic                 sl_gp;
        logic                 sl_gg;
        logic [(k+1)*S-1:0]   sum_nxt;
        cla_stage_t           ctl_q;
        logic [TAG_W-1:0]     tag_q;
        logic [(k+1)*S-1:0]   sum_q;

        if (k == 0) begin : g_src
            always_comb begin
                a_src   = in_a;
                b_src   = sub ? ~in_b : in_b;
                ctl_src = '{valid: in_valid, carry: sub | cin, gp: 1'b1, gg: 1'b0};
                tag_src = in_tag;
            end
            assign sum_nxt = s_sum;
        end else begin : g_src
            always_comb begin
                a_src   = g_stage[k-1].g_pend.a_q;
                b_src   = g_stage[k-1].g_pend.b_q;
                ctl_src = g_stage[k-1].ctl_q;
                tag_src = g_stage[k-1].tag_q;
            end
            assign sum_nxt = {s_sum, g_stage[k-1].sum_q};
        end

        for (genvar j = 0; j < NB; j++) begin : g_blk
            cla_block4 u_blk (
                .a   (a_src[j*CLA_BLK_W +: CLA_BLK_W]),
                .b   (b_src[j*CLA_BLK_W +: CLA_BLK_W]),
                .cin (c[j]),
                .sum (s_sum[j*CLA_BLK_W +: CLA_BLK_W]),
                .gp  (bgp[j]),
                .gg  (bgg[j])
            );
        end

        // Each block carry is formed from the slice carry-in and prefix group terms, not rippled
        always_comb begin
            c[0]  = ctl_src.carry;
            sl_gg = 1'b0;
            sl_gp = 1'b1;
            for (int unsigned j = 0; j < NB; j++) begin
                sl_gg  = bgg[j] | (bgp[j] & sl_gg);
                sl_gp  = sl_gp & bgp[j];
                c[j+1] = sl_gg | (sl_gp & c[0]);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctl_q <= '0;
                tag_q <= '0;
                sum_q <= '0;
            end else if (adv) begin
                ctl_q.valid <= ctl_src.valid;
                if (ctl_src.valid) begin
                    ctl_q.carry <= c[NB];
                    ctl_q.gp    <= ctl_src.gp & sl_gp;
                    ctl_q.gg    <= sl_gg | (sl_gp & ctl_src.gg);
                    tag_q       <= tag_src;
                    sum_q       <= sum_nxt;
                end
            end
        end

        if (k < STAGES - 1) begin : g_pend
            logic [REM-S-1:0] a_q;
            logic [REM-S-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && ctl_src.valid) begin
                    a_q <= a_src[REM-1:S];
                    b_q <= b_src[REM-1:S];
                end
            end
        end

`ifdef CLA_PIPE_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            // carry into the MSB recovered as p_msb ^ sum_msb
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv && ctl_src.valid) begin
                    ovf_q <= a_src[REM-1] ^ b_src[REM-1] ^ s_sum[S-1] ^ c[NB];
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].ctl_q.valid;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].ctl_q.carry;
    assign gp        = g_stage[STAGES-1].ctl_q.gp;
    assign gg        = g_stage[STAGES-1].ctl_q.gg;
    assign out_tag   = g_stage[STAGES-1].tag_q;
`ifdef CLA_PIPE_OVF_EN
    assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
